sr_latch_driver: RTL and testbench

Synchronous write controller for a bank of WIDTH SR latches (NOR-style, active-high s/r). Accepts masked write requests over a valid/ready handshake, converts each into non-overlapping set/reset pulses of fixed width, waits a settle interval, then reads back the latch outputs and reports pass/fail per bit. It sits between clocked control logic and the latch bank, and guarantees the bank never sees the invalid s=r=1 condition.

---
 rtl/sr_latch_pkg.sv | 10 +
 rtl/sr_pulse_timer.sv | 22 ++
 rtl/sr_latch_driver.sv | 84 ++++++++
 tb/tb_sr_latch_driver.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: shared state encoding and timer sizing for the SR latch driver
package sr_latch_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
  localparam int PULSE_DEF = 2;
  localparam int SETTLE_DEF = 1;
  function automatic int tmr_w(input int p, input int s);
    return $clog2((p > s ? p : s) + 1);
  endfunction
  localparam int TMR_W = tmr_w(PULSE_DEF, SETTLE_DEF);
endpackage

// File: rtl/sr_pulse_timer.sv
// sr_pulse_timer: loadable down-counter, expire is high in the last counted cycle
module sr_pulse_timer
  import sr_latch_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    expire = cnt_q == W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: masked write controller producing non-overlapping s/r pulses with readback check
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PULSE_CYCLES = PULSE_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits
);
  localparam int TW = tmr_w(PULSE_CYCLES, SETTLE_CYCLES);
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, mask_q, mask_d, s_q, s_d, r_q, r_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d, set_vec, rst_vec;
  logic done_q, done_d, err_q, err_d, accept, expire, load;
  logic [TW-1:0] load_val;
  sr_pulse_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .expire(expire)
  );
  assign req_ready = state_q == IDLE;
  assign accept = req_valid & req_ready;
  // set and reset vectors are disjoint by construction, so s&r can never be 1
  always_comb begin
    set_vec = req_mask & req_data & ~q_fb;
    rst_vec = req_mask & ~req_data & q_fb;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (|(set_vec | rst_vec) ? PULSE : CHECK) : IDLE;
      PULSE:   state_d = expire ? SETTLE : PULSE;
      SETTLE:  state_d = expire ? CHECK : SETTLE;
      default: state_d = IDLE;
    endcase
    data_d = accept ? req_data : data_q;
    mask_d = accept ? req_mask : mask_q;
    s_d = state_d == PULSE ? (state_q == IDLE ? set_vec : s_q) : '0;
    r_d = state_d == PULSE ? (state_q == IDLE ? rst_vec : r_q) : '0;
    load = state_d != state_q && (state_d == PULSE || state_d == SETTLE);
    load_val = state_d == PULSE ? TW'(PULSE_CYCLES) : TW'(SETTLE_CYCLES);
    done_d = state_q == CHECK;
    err_bits_d = done_d ? mask_q & (q_fb ^ data_q) : err_bits_q;
    err_d = done_d ? |err_bits_d : err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      mask_q <= '0;
      s_q <= '0;
      r_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_bits_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      mask_q <= mask_d;
      s_q <= s_d;
      r_q <= r_d;
      done_q <= done_d;
      err_q <= err_d;
      err_bits_q <= err_bits_d;
    end
  end
  assign s = s_q;
  assign r = r_q;
  assign done = done_q;
  assign err = err_q;
  assign err_bits = err_bits_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed checks of sr_latch_driver against a behavioural latch bank
module tb_sr_latch_driver;
  logic clk, rst_n, req_valid, req_ready, done, err;
  logic [7:0] req_data, req_mask, q_fb, s, r, err_bits;
  logic [7:0] q_m, stuck, load_v;
  logic load_m;
  int total = 0;
  int bad = 0;
  sr_latch_driver #(.WIDTH(8), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_mask(req_mask),
    .q_fb(q_fb),
    .s(s),
    .r(r),
    .done(done),
    .err(err),
    .err_bits(err_bits)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign q_fb = q_m & ~stuck;
  always @(negedge clk) q_m <= load_m ? load_v : (q_m & ~r) | s;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert ((s & r) === 8'h00) else begin
        bad++;
        $error("FAIL sr_overlap s=%h r=%h required=00", s, r);
      end
    end
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic preset(input logic [7:0] v);
    load_v = v;
    load_m = 1'b1;
    @(negedge clk);
    #1 load_m = 1'b0;
  endtask
  task automatic wr(input logic [7:0] d, input logic [7:0] m, input logic [7:0] es,
                    input logic [7:0] er, input logic [7:0] ebits, input bit pulse);
    chk("ready_pre", {7'b0, req_ready}, 8'h01);
    req_valid = 1'b1;
    req_data = d;
    req_mask = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data = ~d;
    req_mask = ~m;
    if (pulse) begin
      repeat (2) begin
        @(negedge clk);
        chk("s_pulse", s, es);
        chk("r_pulse", r, er);
        chk("done_early", {7'b0, done}, 8'h00);
        chk("ready_busy", {7'b0, req_ready}, 8'h00);
      end
      @(negedge clk);
      chk("s_settle", s, 8'h00);
      chk("r_settle", r, 8'h00);
    end
    @(negedge clk);
    chk("s_check", s, 8'h00);
    chk("r_check", r, 8'h00);
    chk("done_early", {7'b0, done}, 8'h00);
    @(negedge clk);
    chk("done", {7'b0, done}, 8'h01);
    chk("err", {7'b0, err}, {7'b0, |ebits});
    chk("err_bits", err_bits, ebits);
    chk("ready_done", {7'b0, req_ready}, 8'h01);
    chk("s_done", s, 8'h00);
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_data = 8'hFF;
    req_mask = 8'hFF;
    stuck = 8'h00;
    load_v = 8'h00;
    load_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", s, 8'h00);
    chk("rst_r", r, 8'h00);
    chk("rst_done", {7'b0, done}, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    chk("rst_err_bits", err_bits, 8'h00);
    rst_n = 1'b1;
    req_valid = 1'b0;
    load_m = 1'b0;
    chk("rst_ready", {7'b0, req_ready}, 8'h01);
    @(negedge clk);
    chk("post_rst_s", s, 8'h00);
    chk("post_rst_done", {7'b0, done}, 8'h00);
    preset(8'h00);
    wr(8'hA5, 8'hFF, 8'hA5, 8'h00, 8'h00, 1'b1);
    #1 chk("q_a5", q_fb, 8'hA5);
    preset(8'hF0);
    wr(8'h0F, 8'h3C, 8'h0C, 8'h30, 8'h00, 1'b1);
    #1 chk("q_cc", q_fb, 8'hCC);
    stuck = 8'h08;
    preset(8'h00);
    wr(8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 1'b1);
    stuck = 8'h00;
    preset(8'h55);
    wr(8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    #1 chk("q_55", q_fb, 8'h55);
    preset(8'h00);
    chk("ready_mid", {7'b0, req_ready}, 8'h01);
    req_valid = 1'b1;
    req_data = 8'hFF;
    req_mask = 8'h0F;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_s", s, 8'h0F);
    chk("mid_r", r, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_s", s, 8'h00);
    chk("mid_rst_r", r, 8'h00);
    chk("mid_rst_done", {7'b0, done}, 8'h00);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_rst", {7'b0, done}, 8'h00);
      chk("idle_after_rst", {7'b0, req_ready}, 8'h01);
    end
    preset(8'h0F);
    wr(8'hF0, 8'hFF, 8'hF0, 8'h0F, 8'h00, 1'b1);
    wr(8'h3C, 8'hFF, 8'h0C, 8'hC0, 8'h00, 1'b1);
    #1 chk("q_3c", q_fb, 8'h3C);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
